// File: rtl/dm_bus_ctrl.sv
// dm_bus_ctrl: sequences one M-stage load/store at a time onto a req/ack memory bus.
// Latency: 3 cycles minimum (IDLE capture, BUSY+ack, DONE), plus one per wait state.
// Backpressure: stall_M holds the pipeline until DONE; optional MEM_TIMEOUT_EN watchdog.
module dm_bus_ctrl #(
  parameter int AW          = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m_valid,
  input  logic          m_write,
  input  logic [AW-1:0] m_addr,
  input  logic [31:0]   m_wdata,
  input  logic [3:0]    m_be,
  output logic          stall_M,
  output logic [31:0]   rdata,
  output logic          rdata_valid,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [31:0]   bus_wdata,
  output logic [3:0]    bus_be,
  input  logic          bus_ack,
  input  logic [31:0]   bus_rdata,
  output logic          bus_err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state;

  // Byte select travels on m_be, so the address LSBs never reach the bus.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^m_addr[1:0];

`ifdef MEM_TIMEOUT_EN
  logic [15:0] tmo_cnt;
`else
  assign bus_err = 1'b0;
`endif

  // Pipeline is released only in the single DONE cycle of an access.
  assign stall_M = m_valid & (state != DONE);

  // Access sequencer: capture in IDLE, hold bus stable in BUSY, release in DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      bus_be      <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      tmo_cnt     <= '0;
      bus_err     <= 1'b0;
`endif
    end else begin
      rdata_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (m_valid) begin
            bus_req   <= 1'b1;
            bus_we    <= m_write;
            bus_addr  <= {m_addr[AW-1:2], 2'b00};
            bus_wdata <= m_wdata;
            bus_be    <= m_be;
            state     <= BUSY;
`ifdef MEM_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
          end
        end
        BUSY: begin
          // An ack arriving on the expiry cycle still completes normally.
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (!bus_we) begin
              rdata       <= bus_rdata;
              rdata_valid <= 1'b1;
            end
            state <= DONE;
          end
`ifdef MEM_TIMEOUT_EN
          else if (tmo_cnt == 16'(TIMEOUT_CYC - 1)) begin
            bus_req <= 1'b0;
            bus_err <= 1'b1;
            if (!bus_we) begin
              rdata       <= 32'hDEAD_BEEF;
              rdata_valid <= 1'b1;
            end
            state <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
`endif
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_bus_ctrl.sv
// Directed bench for dm_bus_ctrl: load/store sequences, wait states, back-to-back,
// async reset mid-access, spurious ack, and the watchdog when MEM_TIMEOUT_EN is set.
// Load data expectations are queued at ack time and retired when rdata_valid pulses.
module tb_dm_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        m_valid;
  logic        m_write;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  logic        stall_M;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err;

  int errors = 0;
  int checks = 0;
  logic [31:0] sb[$];
  logic [31:0] last_rd;

  dm_bus_ctrl #(.AW(32), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .reset(reset),
    .m_valid(m_valid), .m_write(m_write), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_be(m_be),
    .stall_M(stall_M), .rdata(rdata), .rdata_valid(rdata_valid),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Retire one queued load result per rdata_valid pulse.
  always @(negedge clk) begin
    if (rdata_valid === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_rdata_valid", 64'(rdata_valid), 64'd0);
      else chk("rdata", 64'(rdata), 64'(sb.pop_front()));
    end
  end

  // Called just after a rising edge with the FSM in IDLE; returns just after the
  // edge that moves DONE back to IDLE.
  task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int waits, input logic [31:0] rd);
    int stalls;
    stalls = 0;
    m_valid = 1'b1; m_write = wr; m_addr = addr; m_wdata = wdata; m_be = be;
    @(negedge clk);
    chk("idle_bus_req", 64'(bus_req), 64'd0);
    stalls += int'(stall_M);
    for (int k = 0; k <= waits; k++) begin
      @(posedge clk); #1;
      bus_ack   = (k == waits);
      bus_rdata = (k == waits) ? rd : 32'h0BAD_F00D;
      if (k == waits && !wr) begin
        sb.push_back(rd);
        last_rd = rd;
      end
      @(negedge clk);
      chk("busy_req",   64'(bus_req),   64'd1);
      chk("busy_we",    64'(bus_we),    64'(wr));
      chk("busy_addr",  64'(bus_addr),  64'({addr[31:2], 2'b00}));
      chk("busy_wdata", 64'(bus_wdata), 64'(wdata));
      chk("busy_be",    64'(bus_be),    64'(be));
      stalls += int'(stall_M);
    end
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(negedge clk);
    chk("done_stall",  64'(stall_M),     64'd0);
    chk("done_req",    64'(bus_req),     64'd0);
    chk("done_rvalid", 64'(rdata_valid), 64'(!wr));
    chk("stall_cycles", 64'(stalls), 64'(waits + 2));
    @(posedge clk); #1;
    m_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; m_valid = 1'b0; m_write = 1'b0; m_addr = '0; m_wdata = '0;
    m_be = '0; bus_ack = 1'b0; bus_rdata = '0; last_rd = '0;
    #3;
    chk("rst_bus_req", 64'(bus_req), 64'd0);
    chk("rst_bus_we", 64'(bus_we), 64'd0);
    chk("rst_bus_addr", 64'(bus_addr), 64'd0);
    chk("rst_bus_wdata", 64'(bus_wdata), 64'd0);
    chk("rst_bus_be", 64'(bus_be), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_rdata_valid", 64'(rdata_valid), 64'd0);
    chk("rst_bus_err", 64'(bus_err), 64'd0);
    chk("rst_stall", 64'(stall_M), 64'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    // Zero-wait load, word-aligned address.
    access(1'b0, 32'h0000_1004, 32'h0, 4'hF, 0, 32'h1234_5678);
    // Unaligned store with four wait states.
    access(1'b1, 32'h0000_2003, 32'hCAFE_BABE, 4'b1000, 4, 32'h0);
    chk("rdata_hold_after_sw", 64'(rdata), 64'(last_rd));
    // Back-to-back load then store; second access checks bus_req low in IDLE.
    access(1'b0, 32'h0000_4008, 32'h0, 4'hF, 1, 32'hA5A5_5A5A);
    access(1'b1, 32'h0000_400E, 32'h0102_0304, 4'b0011, 2, 32'h0);

    // Spurious ack in IDLE.
    bus_ack = 1'b1; bus_rdata = 32'hFFFF_0000;
    @(negedge clk);
    chk("spur_rvalid", 64'(rdata_valid), 64'd0);
    chk("spur_req", 64'(bus_req), 64'd0);
    @(posedge clk); #1; bus_ack = 1'b0;
    @(negedge clk);
    chk("spur_rvalid2", 64'(rdata_valid), 64'd0);
    chk("spur_req2", 64'(bus_req), 64'd0);
    chk("spur_rdata_hold", 64'(rdata), 64'(last_rd));
    @(posedge clk); #1;

    // Asynchronous reset in the middle of BUSY.
    m_valid = 1'b1; m_write = 1'b0; m_addr = 32'h0000_3000; m_be = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #2;
    chk("pre_rst_req", 64'(bus_req), 64'd1);
    reset = 1'b1; #1;
    chk("async_rst_req", 64'(bus_req), 64'd0);
    chk("async_rst_addr", 64'(bus_addr), 64'd0);
    m_valid = 1'b0;
    @(negedge clk); reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_idle_req", 64'(bus_req), 64'd0);
    end
    chk("post_rst_rdata", 64'(rdata), 64'd0);
    @(posedge clk); #1;
    access(1'b0, 32'h0000_5010, 32'h0, 4'hF, 3, 32'h7654_3210);

`ifdef MEM_TIMEOUT_EN
    begin
      int n;
      n = 0;
      m_valid = 1'b1; m_write = 1'b0; m_addr = 32'h0000_6000; m_be = 4'hF;
      sb.push_back(32'hDEAD_BEEF);
      last_rd = 32'hDEAD_BEEF;
      @(negedge clk);
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (!bus_req) break;
        n++;
      end
      chk("tmo_busy_cycles", 64'(n), 64'd8);
      chk("tmo_bus_err", 64'(bus_err), 64'd1);
      chk("tmo_stall", 64'(stall_M), 64'd0);
      chk("tmo_rvalid", 64'(rdata_valid), 64'd1);
      @(posedge clk); #1; m_valid = 1'b0;
      access(1'b1, 32'h0000_6004, 32'h1111_2222, 4'hF, 0, 32'h0);
      chk("tmo_err_sticky", 64'(bus_err), 64'd1);
      reset = 1'b1; #1;
      chk("tmo_err_rst", 64'(bus_err), 64'd0);
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1;
    end
`else
    chk("no_tmo_bus_err", 64'(bus_err), 64'd0);
`endif

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
